// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file for the pipelined CPU. It has two combinational read ports
//   and one synchronous write port. Optional features are a hard-wired zero
//   register and write-to-read bypass. Each register has a pending
//   (scoreboard) bit for the hazard unit. A sequenced bulk-clear engine
//   zeroes one entry per cycle.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   rd_addr1/2             read addresses
//   rd_data1/2             read data (combinational, optional bypass)
//   rd_busy1/2             pending bit of the addressed register
//   wr_en, wr_addr, wr_data  writeback port; clears the pending bit
//   iss_en, iss_addr       issue port; sets the pending bit
//   clr_req                pulse that starts the bulk clear
//   clr_busy               high while the bulk clear runs (2**ADDR_W cycles)

module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;

    logic wr_ok;
    logic iss_ok;

    // The clear engine owns the array while it runs, so both ports are
    // dropped in that window. Register 0 drops them when it is hard-wired.
    assign wr_ok  = wr_en  && !clr_busy && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign iss_ok = iss_en && !clr_busy && !((ZERO_REG != 0) && (iss_addr == '0));

    // Read ports. The zero-register override comes last so that it beats
    // the bypass path.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        rd_data1 = mem[rd_addr1];
        rd_busy1 = pending[rd_addr1];
        rd_data2 = mem[rd_addr2];
        rd_busy2 = pending[rd_addr2];

        if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            rd_busy1 = 1'b0;
        end
        if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            rd_busy2 = 1'b0;
        end

        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end
    end

    // Storage, scoreboard and clear FSM. clr_busy is registered alongside
    // the state, so it is high exactly while the FSM is in CLEAR.
    // NOTE: all state is assigned with non-blocking <= so that every
    // register samples pre-edge values, whatever order the statements run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            pending  <= '0;
            // NOTE: the storage array is reset on purpose. Software
            // depends on the contents being zero after reset, so the array
            // cannot be inferred as a RAM macro without a reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        mem[wr_addr]     <= wr_data;
                        pending[wr_addr] <= 1'b0;
                    end
                    // Coming after the write, this set wins on an address
                    // clash: the newly issued producer is still outstanding.
                    if (iss_ok) begin
                        pending[iss_addr] <= 1'b1;
                    end
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[cnt]     <= '0;
                    pending[cnt] <= 1'b0;
                    // The terminal count is compared explicitly; the
                    // counter never carries out.
                    if (cnt == LAST_IDX) begin
                        cnt      <= '0;
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Directed bench for regfile_scoreboard. It runs two instances on the same
//   stimulus: the default configuration (bypass on) and a bypass-off copy.
//   Inputs change on the falling edge. Outputs are sampled 1 time unit later,
//   well away from the rising edge.

module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, iss_addr;
    logic [31:0] wr_data;
    logic        wr_en, iss_en, clr_req;

    logic [31:0] rd_data1, rd_data2;
    logic        rd_busy1, rd_busy2, clr_busy;

    logic [31:0] nb_rd_data1, nb_rd_data2;
    logic        nb_rd_busy1, nb_rd_busy2, nb_clr_busy;

    int n_vec = 0;
    int n_err = 0;
    int cycles;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2),
        .rd_busy1(nb_rd_busy1), .rd_busy2(nb_rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .clr_req(clr_req), .clr_busy(nb_clr_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse clr_req and count the falling edges on which clr_busy is high.
    // The count is capped at 64, so a stuck FSM still ends the loop.
    task automatic count_clear(output int n);
        @(negedge clk); clr_req = 1'b1;
        @(negedge clk); clr_req = 1'b0;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (!clr_busy) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
        rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; iss_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state: every location reads zero and not busy.
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd_addr1 = 5'(a); rd_addr2 = 5'(31 - a);
            #1;
            check("rst_data1", rd_data1, 32'h0);
            check("rst_data2", rd_data2, 32'h0);
            check("rst_busy1", {31'b0, rd_busy1}, 32'h0);
            check("rst_busy2", {31'b0, rd_busy2}, 32'h0);
        end
        check("rst_clr_busy", {31'b0, clr_busy}, 32'h0);

        // Write, then read: bypass on the same cycle, storage on the next.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr1 = 5'd5;
        #1;
        check("wr_bypass", rd_data1, 32'hDEADBEEF);
        check("wr_nobypass_old", nb_rd_data1, 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("wr_stored", rd_data1, 32'hDEADBEEF);
        check("wr_stored_nb", nb_rd_data1, 32'hDEADBEEF);

        // Zero register: the write and the issue to register 0 are ignored.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        iss_en = 1'b1; iss_addr = 5'd0; rd_addr1 = 5'd0;
        #1;
        check("zero_data_same", rd_data1, 32'h0);
        check("zero_busy_same", {31'b0, rd_busy1}, 32'h0);
        @(negedge clk);
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        check("zero_data_after", rd_data1, 32'h0);
        check("zero_busy_after", {31'b0, rd_busy1}, 32'h0);
        check("zero_data_nb", nb_rd_data1, 32'h0);

        // Scoreboard: issue marks the register pending; writeback clears it.
        @(negedge clk);
        iss_en = 1'b1; iss_addr = 5'd7; rd_addr2 = 5'd7;
        #1;
        check("iss_busy_same", {31'b0, rd_busy2}, 32'h0);
        @(negedge clk);
        iss_en = 1'b0;
        #1;
        check("iss_busy_next", {31'b0, rd_busy2}, 32'h1);
        check("iss_busy_next_nb", {31'b0, nb_rd_busy2}, 32'h1);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        #1;
        check("wb_busy_masked", {31'b0, rd_busy2}, 32'h0);
        check("wb_busy_nb", {31'b0, nb_rd_busy2}, 32'h1);
        check("wb_data_bypass", rd_data2, 32'h55);
        check("wb_data_nb", nb_rd_data2, 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("wb_busy_after", {31'b0, rd_busy2}, 32'h0);
        check("wb_data_after", rd_data2, 32'h55);

        // Issue and write to the same register: the data lands and the set wins.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A50009;
        iss_en = 1'b1; iss_addr = 5'd9; rd_addr1 = 5'd9;
        #1;
        check("iw_data_same", rd_data1, 32'hA5A50009);
        check("iw_busy_same", {31'b0, rd_busy1}, 32'h0);
        @(negedge clk);
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        check("iw_data_next", rd_data1, 32'hA5A50009);
        check("iw_busy_next", {31'b0, rd_busy1}, 32'h1);

        // Bulk clear: fill 1..31, mark 3 pending, then run the clear.
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'h10000000 + 32'(a);
        end
        @(negedge clk);
        wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd3;
        @(negedge clk);
        iss_en = 1'b0; rd_addr1 = 5'd3; rd_addr2 = 5'd31;
        #1;
        check("fill_busy3", {31'b0, rd_busy1}, 32'h1);
        check("fill_data3", rd_data1, 32'h10000003);
        check("fill_data31", rd_data2, 32'h1000001F);

        @(negedge clk);
        clr_req = 1'b1;
        #1;
        check("clr_idle_on_req", {31'b0, clr_busy}, 32'h0);
        @(negedge clk);
        cycles = 0;
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
            if (i == 5) begin
                // Entries 0..4 are already cleared at this point.
                wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hFFFF;
                iss_en = 1'b1; iss_addr = 5'd1;
                rd_addr1 = 5'd2; rd_addr2 = 5'd20;
            end
            if (i == 10) clr_req = 1'b1;
            #1;
            if (!clr_busy) break;
            if (i == 5) begin
                check("clr_no_bypass", rd_data1, 32'h0);
                check("clr_partial_live", rd_data2, 32'h10000014);
            end
            cycles++;
            @(negedge clk);
        end
        check("clr_length", 32'(cycles), 32'd32);

        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd_addr1 = 5'(a); rd_addr2 = 5'(31 - a);
            #1;
            check("clr_data1", rd_data1, 32'h0);
            check("clr_data2", rd_data2, 32'h0);
            check("clr_busy1", {31'b0, rd_busy1}, 32'h0);
            check("clr_busy2", {31'b0, rd_busy2}, 32'h0);
        end

        // Asynchronous reset in the middle of a clear.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hCAFE0020;
        @(negedge clk);
        wr_addr = 5'd31; wr_data = 32'hCAFE0031;
        @(negedge clk);
        wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd25;
        @(negedge clk);
        iss_en = 1'b0; rd_addr1 = 5'd20; rd_addr2 = 5'd25;
        #1;
        check("rc_pre_data20", rd_data1, 32'hCAFE0020);
        check("rc_pre_busy25", {31'b0, rd_busy2}, 32'h1);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("rc_busy_c10", {31'b0, clr_busy}, 32'h1);
        check("rc_partial20", rd_data1, 32'hCAFE0020);
        #1;
        rst_n = 1'b0;
        #1;
        check("rc_clr_busy_drop", {31'b0, clr_busy}, 32'h0);
        check("rc_data20", rd_data1, 32'h0);
        check("rc_busy25", {31'b0, rd_busy2}, 32'h0);
        rd_addr2 = 5'd31;
        #1;
        check("rc_data31", rd_data2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        count_clear(cycles);
        check("rc_fresh_length", 32'(cycles), 32'd32);
        check("rc_nb_idle", {31'b0, nb_clr_busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-cycle CPU register file: 2 combinational read ports, 1 synchronous write port.
- Adds an optional hard-wired zero register, optional write-to-read bypass, and per-register pending (scoreboard) bits for the pipelined datapath's hazard unit.
- Adds a sequenced bulk-clear engine.
- Sits between decode (reads/issue) and writeback (write) in the pipelined CPU.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 always reads 0, is never pending, and writes/issues to it are ignored.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- rd_addr1  input  ADDR_W  Read port 1 address.
- rd_addr2  input  ADDR_W  Read port 2 address.
- rd_data1  output  DATA_W  Read port 1 data (combinational).
- rd_data2  output  DATA_W  Read port 2 data (combinational).
- rd_busy1  output  1  Register at rd_addr1 has a pending producer.
- rd_busy2  output  1  Register at rd_addr2 has a pending producer.
- wr_en  input  1  Writeback enable.
- wr_addr  input  ADDR_W  Writeback destination.
- wr_data  input  DATA_W  Writeback data.
- iss_en  input  1  Issue: mark iss_addr pending.
- iss_addr  input  ADDR_W  Destination of the issued instruction.
- clr_req  input  1  Single-cycle pulse that starts the bulk clear.
- clr_busy  output  1  Bulk clear in progress.

Behaviour:
- Reset (rst_n=0, asynchronous): all registers = 0, all pending bits = 0, FSM = IDLE, clear counter = 0, clr_busy = 0.
  - rd_data* reflect zeroed storage immediately; rd_busy* = 0.
- Reads: combinational, zero latency.
  - rd_dataN = storage[rd_addrN].
  - If BYPASS=1, wr_en=1, wr_addr==rd_addrN and the write is not ignored (see zero register and CLEAR rules), rd_dataN = wr_data instead.
  - ZERO_REG=1 and rd_addrN==0: rd_dataN = 0 and rd_busyN = 0, regardless of any other input.
- Write: at posedge with wr_en=1, storage[wr_addr] <= wr_data and pending[wr_addr] <= 0.
  - Ignored when ZERO_REG=1 and wr_addr==0, or while clr_busy=1.
- Issue: at posedge with iss_en=1, pending[iss_addr] <= 1.
  - Ignored when ZERO_REG=1 and iss_addr==0, or while clr_busy=1.
- Issue and write to the same address in the same cycle: the data is written and the pending bit ends at 1 (set wins; the new producer is still outstanding).
- rd_busyN = pending[rd_addrN], masked to 0 when BYPASS=1 and an accepted write to rd_addrN occurs this cycle.
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req=1. The counter is already 0.
  - In CLEAR, each cycle: storage[cnt] <= 0, pending[cnt] <= 0, cnt <= cnt+1.
  - When cnt == 2**ADDR_W-1, clear that entry, reset cnt to 0 and return to IDLE.
  - clr_busy = 1 exactly while in CLEAR, which lasts 2**ADDR_W cycles (32 at default).
  - clr_req while in CLEAR is ignored (no restart).
  - Reads remain live during CLEAR and return the partially-cleared contents; bypass is inactive because writes are ignored.
- Reset mid-clear: rst_n=0 aborts immediately to IDLE with everything zeroed.
- Counter wrap: the address counter is ADDR_W bits wide; the terminal count is compared explicitly, with no overflow bit.

Test Plan:
- Reset and read: rst_n=0, then 1; read addresses 0..31 -> all rd_data=0, rd_busy=0, clr_busy=0.
- Write then read: write addr 5 = 0xDEADBEEF -> same cycle rd_data1 (addr 5) = 0xDEADBEEF via bypass; next cycle, with wr_en=0, still 0xDEADBEEF. With BYPASS=0, the same-cycle read returns the old value 0.
- Zero register: write addr 0 = 0x1234 and issue addr 0 -> rd_data1(0) = 0, rd_busy1 = 0 forever.
- Scoreboard: issue addr 7 -> next cycle rd_busy2(7) = 1. Write addr 7 = 0x55 -> rd_busy2 masked to 0 in that cycle and 0 thereafter. Same-cycle issue and write to addr 9 -> storage[9] = written data, rd_busy(9) = 1 next cycle.
- Bulk clear: fill 1..31 with nonzero values and mark addr 3 pending; pulse clr_req -> clr_busy high for exactly 32 cycles. Writes and issues during CLEAR are dropped; afterwards all reads = 0 and all busy = 0. A second clr_req mid-clear does not extend the 32 cycles.
- Async reset mid-clear: assert rst_n=0 at clear cycle 10, between clock edges -> clr_busy drops immediately and all storage and pending bits = 0. A fresh clr_req after release takes 32 cycles again.
